// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit word memory acting as the responder side
// of the CPU memory interface. Each accepted request completes with a
// one-cycle mem_resp pulse LATENCY cycles after the accept edge.
// Optional build macro: MEM_RANGE_CHECK_EN adds mem_err and suppresses
// accesses whose address bits above the array are nonzero.
// Array contents are never touched by reset; they rely on power-up zero.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic        mem_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) + 1 : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic            r_we;
    logic            r_oor;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_complete;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_wdata;
    logic [3:0]      w_be;
    logic            w_we;
    logic            w_oor;
    logic            w_req_oor;
    logic            w_unused_addr;

    // Out-of-range detection on the live address (only meaningful at accept)
`ifdef MEM_RANGE_CHECK_EN
    assign w_req_oor     = |mem_address[31:AW+2];
    assign w_unused_addr = ^mem_address[1:0];
`else
    assign w_req_oor     = 1'b0;
    assign w_unused_addr = ^{mem_address[31:AW+2], mem_address[1:0]};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; completion uses live inputs when LATENCY=1 commits
    // on the accept edge itself, otherwise the captured transaction
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_idx        = r_idx;
        w_wdata      = r_wdata;
        w_be         = r_be;
        w_we         = r_we;
        w_oor        = r_oor;
        case (r_state)
            S_IDLE: begin
                w_idx   = mem_address[AW+1:2];
                w_wdata = mem_wdata;
                w_be    = mem_byte_enable;
                w_we    = mem_write;
                w_oor   = w_req_oor;
                if (mem_read || mem_write) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_complete   = 1'b1;
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_complete   = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Transaction capture, latency counter and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CW'(LATENCY - 1);
                r_idx   <= mem_address[AW+1:2];
                r_wdata <= mem_wdata;
                r_be    <= mem_byte_enable;
                r_we    <= mem_write;
                r_oor   <= w_req_oor;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_complete && !w_we) begin
                r_rdata <= w_oor ? 32'hDEADBEEF : r_mem[w_idx];
            end
        end
    end

    // Array write commit; a reset on the commit edge aborts the write
    always_ff @(posedge clk) begin
        if (!rst && w_complete && w_we && !w_oor) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_resp  = (r_state == S_RESP);
`ifdef MEM_RANGE_CHECK_EN
    assign mem_err   = (r_state == S_RESP) && r_oor;
`endif

endmodule
